data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for a shared 32-bit data memory; every grant runs IDLE -> ACCESS -> DONE.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
module data_mem_arbiter #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter bit          RD_ZERO_ON_ERR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // 34 bits so that 4*DEPTH_WORDS does not wrap for the largest memories.
  localparam logic [33:0] ADDR_LIMIT = 34'(DEPTH_WORDS) << 2;

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        gnt;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a} >= ADDR_LIMIT);
  endfunction

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  always_comb gnt = (req0 && req1) ? ptr_q : !req0;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && (req0 || req1)) ptr_d = !gnt;
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb gnt = !req0;
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d   = gnt;
          we_d    = gnt ? we1 : we0;
          addr_d  = gnt ? addr1 : addr0;
          wdata_d = gnt ? wdata1 : wdata0;
          err_d   = addr_err(addr_d);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!err_q && !we_q) begin
          if (win_q) rdata1_d = mem_rdata;
          else       rdata0_d = mem_rdata;
        end else if (err_q && RD_ZERO_ON_ERR) begin
          if (win_q) rdata1_d = '0;
          else       rdata0_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Memory strobes exist only in ACCESS, and an errored access never reaches memory.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (state_q == ACCESS) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_write = we_q & ~err_q;
      mem_read  = ~we_q & ~err_q;
    end
  end

  assign ack0   = (state_q == DONE) && !win_q;
  assign ack1   = (state_q == DONE) && win_q;
  assign err0   = ack0 && err_q;
  assign err1   = ack1 && err_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: transaction-level reference model, directed cases, random traffic.
module tb_data_mem_arbiter;
  localparam int DEPTH = 1024;
  localparam bit RDZ   = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1, mem_write, mem_read;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  data_mem_arbiter #(.DEPTH_WORDS(DEPTH), .RD_ZERO_ON_ERR(RDZ)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
  );

  // Memory stub seen by the DUT, and an independent copy owned by the model.
  logic [31:0] smem [DEPTH];
  logic [31:0] mmem [DEPTH];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  assign mem_rdata = mem_read ? smem[mem_addr[11:2]] : 32'h0;

  always @(posedge clock) if (mem_write) smem[mem_addr[11:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one grant per 3 cycles, access in the cycle after sampling, ack the cycle after.
  bit          live = 1'b0;
  logic        e_ack0 = 0, e_ack1 = 0, e_err0 = 0, e_err1 = 0, e_mw = 0, e_mr = 0, e_acc = 0;
  logic [31:0] e_ma = '0, e_md = '0, e_rd0 = '0, e_rd1 = '0;
  bit          pend = 0, p_port = 0, p_we = 0, p_err = 0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  int          wait_n = 0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  bit          ptr = 0;
`endif

  always @(posedge clock) begin : model
    bit g;
    e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
    e_acc = 0; e_mw = 0; e_mr = 0; e_ma = '0; e_md = '0;
    if (pend) begin
      if (p_we && !p_err) mmem[p_addr[11:2]] = p_wdata;
      if (!reset) begin
        if (p_port) begin e_ack1 = 1; e_err1 = p_err; end
        else        begin e_ack0 = 1; e_err0 = p_err; end
        if (!p_err && !p_we) begin
          if (p_port) e_rd1 = mmem[p_addr[11:2]];
          else        e_rd0 = mmem[p_addr[11:2]];
        end else if (p_err && RDZ) begin
          if (p_port) e_rd1 = '0;
          else        e_rd0 = '0;
        end
      end
      pend = 0;
    end
    if (reset) begin
      e_rd0 = '0; e_rd1 = '0; wait_n = 0; live = 1'b1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      ptr = 0;
`endif
    end else if (wait_n > 0) begin
      wait_n--;
    end else if (req0 || req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      g = (req0 && req1) ? ptr : !req0;
      ptr = !g;
`else
      g = !req0;
`endif
      p_port  = g;
      p_we    = g ? we1 : we0;
      p_addr  = g ? addr1 : addr0;
      p_wdata = g ? wdata1 : wdata0;
      p_err   = (p_addr % 4 != 0) || ({32'h0, p_addr} >= 64'(4 * DEPTH));
      pend    = 1;
      wait_n  = 2;
      e_acc = 1; e_ma = p_addr; e_md = p_wdata;
      e_mw  = p_we && !p_err;
      e_mr  = !p_we && !p_err;
    end
  end

  always @(negedge clock) begin : compare
    if (live) begin
      chk("ack0", 32'(ack0), 32'(e_ack0));
      chk("ack1", 32'(ack1), 32'(e_ack1));
      chk("err0", 32'(err0), 32'(e_err0));
      chk("err1", 32'(err1), 32'(e_err1));
      chk("mem_write", 32'(mem_write), 32'(e_mw));
      chk("mem_read", 32'(mem_read), 32'(e_mr));
      if (e_mw || e_mr) begin
        chk("mem_addr", mem_addr, e_ma);
        chk("mem_wdata", mem_wdata, e_md);
      end else if (!e_acc) begin
        chk("mem_addr_idle", mem_addr, 32'h0);
        chk("mem_wdata_idle", mem_wdata, 32'h0);
      end
      chk("rdata0", rdata0, e_rd0);
      chk("rdata1", rdata1, e_rd1);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Issue one request from an idle arbiter and wait (bounded) for its ack.
  task automatic do_req(input bit port, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output bit e, output int nmem, output int noth);
    bit got = 0;
    lat = 0; nmem = 0; noth = 0; e = 0;
    if (port) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      lat++;
      nmem += int'(mem_write) + int'(mem_read);
      noth += port ? int'(ack0) : int'(ack1);
      got = port ? ack1 : ack0;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL ack_timeout port%0d: no ack within 20 cycles", port);
    end
    e = port ? err1 : err0;
    #1;
    if (port) req1 = 0; else req0 = 0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 15);
    if (r == 0) return 32'($urandom_range(0, 255)) | 32'h1;
    if (r == 1) return 32'h1000 + 32'($urandom_range(0, 1000)) * 4;
    if (r == 2) return 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  initial begin : main
    int lat, nmem, noth, n;
    bit e, a0, a1, busy0, busy1;
    int order[$];
    int exp_order[4];
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < DEPTH; i++) begin
      smem[i] = init_word(i);
      mmem[i] = init_word(i);
    end
    tick(); tick();
    chk("rst_ack0", 32'(ack0), 32'h0);
    chk("rst_ack1", 32'(ack1), 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    reset = 0;
    tick();

    // Write then read back on port 0.
    do_req(0, 1, 32'h10, 32'hDEADBEEF, lat, e, nmem, noth);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_mem_cycles", 32'(nmem), 32'd1);
    chk("wr_err0", 32'(e), 32'h0);
    do_req(0, 0, 32'h10, 32'h0, lat, e, nmem, noth);
    chk("rd_rdata0", rdata0, 32'hDEADBEEF);
    chk("rd_err0", 32'(e), 32'h0);
    chk("rd_latency", 32'(lat), 32'd2);

    // Errored accesses on port 1, each preceded by a good read so the zeroing is visible.
    do_req(1, 0, 32'h40, 32'h0, lat, e, nmem, noth);
    chk("p1_rd_rdata1", rdata1, init_word(16));
    do_req(1, 0, 32'h6, 32'h0, lat, e, nmem, noth);
    chk("mis_err1", 32'(e), 32'h1);
    chk("mis_mem_cycles", 32'(nmem), 32'h0);
    chk("mis_rdata1", rdata1, 32'h0);
    do_req(1, 0, 32'h44, 32'h0, lat, e, nmem, noth);
    chk("p1_rd2_rdata1", rdata1, init_word(17));
    do_req(1, 0, 32'(4 * DEPTH), 32'h0, lat, e, nmem, noth);
    chk("oor_err1", 32'(e), 32'h1);
    chk("oor_mem_cycles", 32'(nmem), 32'h0);
    chk("oor_rdata1", rdata1, 32'h0);

    // Port 0 read result survives a later port 1 write.
    do_req(0, 1, 32'h20, 32'h1234, lat, e, nmem, noth);
    do_req(0, 0, 32'h20, 32'h0, lat, e, nmem, noth);
    chk("keep_rdata0_a", rdata0, 32'h1234);
    do_req(1, 1, 32'h24, 32'h5555AAAA, lat, e, nmem, noth);
    chk("keep_rdata0_b", rdata0, 32'h1234);
    chk("keep_no_ack0", 32'(noth), 32'h0);

    // Both ports held high: grant order after a fresh reset.
    do_reset();
    req0 = 1; we0 = 0; addr0 = 32'h0;
    req1 = 1; we1 = 0; addr1 = 32'h4;
    for (int i = 0; i < 30 && order.size() < 4; i++) begin
      @(negedge clock);
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
    end
    #1; req0 = 0; req1 = 0;
    tick();
    chk("tie_grants", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("tie_order", 32'(order[i]), 32'(exp_order[i]));

    // Reset while a port 0 write is in ACCESS.
    req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hCAFEF00D;
    for (int i = 0; i < 10 && !mem_write; i++) @(negedge clock);
    chk("abort_saw_write", 32'(mem_write), 32'h1);
    #1; reset = 1; req0 = 0;
    @(negedge clock);
    chk("abort_ack0", 32'(ack0), 32'h0);
    chk("abort_mem_write", 32'(mem_write), 32'h0);
    chk("abort_mem_read", 32'(mem_read), 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    #1; reset = 0;
    n = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clock); n += int'(ack0); end
    chk("abort_no_late_ack", 32'(n), 32'h0);
    #1;
    req0 = 1; we0 = 0; addr0 = 32'h30;
    req1 = 1; we1 = 0; addr1 = 32'h34;
    a0 = 0; a1 = 0;
    for (int i = 0; i < 10 && !a0 && !a1; i++) begin
      @(negedge clock); a0 = ack0; a1 = ack1;
    end
    chk("post_reset_first_grant_p0", 32'(a0), 32'h1);
    #1; req0 = 0;
    a1 = 0;
    for (int i = 0; i < 10 && !a1; i++) begin @(negedge clock); a1 = ack1; end
    chk("post_reset_p1_served", 32'(a1), 32'h1);
    #1; req1 = 0;
    tick();

    // Random traffic from both requesters with occasional resets.
    busy0 = 0; busy1 = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      a0 = ack0; a1 = ack1;
      #1;
      if (reset) reset = 0;
      else if ($urandom_range(0, 199) == 0) reset = 1;
      if (a0) begin req0 = 0; busy0 = 0; end
      if (a1) begin req1 = 0; busy1 = 0; end
      if (!busy0 && $urandom_range(0, 3) == 0) begin
        busy0 = 1; req0 = 1; we0 = 1'($urandom_range(0, 1)); addr0 = rand_addr(); wdata0 = $urandom();
      end
      if (!busy1 && $urandom_range(0, 2) == 0) begin
        busy1 = 1; req1 = 1; we1 = 1'($urandom_range(0, 1)); addr1 = rand_addr(); wdata1 = $urandom();
      end
    end
    reset = 0;
    for (int i = 0; i < 20 && (busy0 || busy1); i++) begin
      @(negedge clock);
      a0 = ack0; a1 = ack1;
      #1;
      if (a0) begin req0 = 0; busy0 = 0; end
      if (a1) begin req1 = 0; busy1 = 0; end
    end
    req0 = 0; req1 = 0;
    tick(); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
